// File: rtl/uart_pkg.sv
// Shared definitions for the UART message sequencer: FSM states,
// ASCII framing constants and default sizing.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_PAD = 8'h2E;

    localparam int DEFAULT_MSG_LEN    = 16;
    localparam int DEFAULT_GAP_CYCLES = 1000;

endpackage

// File: rtl/uart_msg_sequencer_rom.sv
// Message ROM with a registered read port. The read register doubles as the
// transmit data register, so a byte only changes when rd_en is pulsed.
// Text is "Hello UART msg", padded with '.', always terminated by CR LF.
module msg_rom
    import uart_pkg::*;
#(
    parameter  int MSG_LEN = DEFAULT_MSG_LEN,
    localparam int IDX_W   = $clog2(MSG_LEN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] addr,
    output logic [7:0]       rd_data
);

    logic [7:0] rom_byte;
    logic [7:0] data_d;
    logic [7:0] data_q;
    int         pos;

    // ROM contents: the last two positions are always CR LF
    always_comb begin
        pos      = int'(addr);
        rom_byte = ASCII_PAD;
        if (pos == MSG_LEN - 1) begin
            rom_byte = ASCII_LF;
        end else if (pos == MSG_LEN - 2) begin
            rom_byte = ASCII_CR;
        end else begin
            case (pos)
                0:       rom_byte = 8'h48;
                1:       rom_byte = 8'h65;
                2:       rom_byte = 8'h6C;
                3:       rom_byte = 8'h6C;
                4:       rom_byte = 8'h6F;
                5:       rom_byte = 8'h20;
                6:       rom_byte = 8'h55;
                7:       rom_byte = 8'h41;
                8:       rom_byte = 8'h52;
                9:       rom_byte = 8'h54;
                10:      rom_byte = 8'h20;
                11:      rom_byte = 8'h6D;
                12:      rom_byte = 8'h73;
                13:      rom_byte = 8'h67;
                default: rom_byte = ASCII_PAD;
            endcase
        end
    end

    // Load a new byte only on a read, otherwise hold what is being offered
    always_comb begin
        data_d = data_q;
        if (rd_en) begin
            data_d = rom_byte;
        end
    end

    // Read register, cleared by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= 8'h00;
        end else begin
            data_q <= data_d;
        end
    end

    assign rd_data = data_q;

endmodule

// File: rtl/uart_msg_sequencer.sv
// Streams the ROM message into uart_tx over a valid/ready byte handshake,
// either once or repeatedly with an idle gap between repeats.
module uart_msg_sequencer
    import uart_pkg::*;
#(
    parameter  int MSG_LEN    = DEFAULT_MSG_LEN,
    parameter  int GAP_CYCLES = DEFAULT_GAP_CYCLES,
    localparam int IDX_W      = $clog2(MSG_LEN)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       repeat_en,
    input  logic       abort,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       msg_done
);

    localparam int               GAP_W    = $clog2(GAP_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = '1;

    state_t           state_d;
    state_t           state_q;
    logic [IDX_W-1:0] idx_d;
    logic [IDX_W-1:0] idx_q;
    logic [GAP_W-1:0] gap_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q;
    logic             tx_valid_d;
    logic             tx_valid_q;
    logic             rom_rd_en;
    logic             done_pulse;
    logic             xfer;

    assign xfer = tx_valid_q && tx_ready;

    // Next-state logic; an offered byte is never withdrawn, abort acts only
    // once the current byte has been accepted or while idling in the gap
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        gap_cnt_d  = gap_cnt_q;
        tx_valid_d = tx_valid_q;
        rom_rd_en  = 1'b0;
        done_pulse = 1'b0;
        case (state_q)
            IDLE: begin
                tx_valid_d = 1'b0;
                if (start) begin
                    idx_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                rom_rd_en  = 1'b1;
                tx_valid_d = 1'b1;
                state_d    = SEND;
            end
            SEND: begin
                if (xfer) begin
                    tx_valid_d = 1'b0;
                    idx_d      = '0;
                    if (idx_q == LAST_IDX) begin
                        done_pulse = 1'b1;
                        if (abort) begin
                            state_d = IDLE;
                        end else begin
                            gap_cnt_d = '0;
                            state_d   = GAP;
                        end
                    end else if (abort) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (gap_cnt_q == GAP_LAST) begin
                    idx_d   = '0;
                    state_d = repeat_en ? FETCH : IDLE;
                end else if (gap_cnt_q != GAP_MAX) begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                tx_valid_d = 1'b0;
                idx_d      = '0;
                state_d    = IDLE;
            end
        endcase
    end

    // State, index, gap counter and valid registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            gap_cnt_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            gap_cnt_q  <= gap_cnt_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    msg_rom #(
        .MSG_LEN (MSG_LEN)
    ) u_rom (
        .clk     (clk),
        .reset   (reset),
        .rd_en   (rom_rd_en),
        .addr    (idx_q),
        .rd_data (tx_data)
    );

    assign tx_valid = tx_valid_q;
    assign busy     = (state_q != IDLE);
    assign msg_done = done_pulse;

endmodule

// File: tb/tb_uart_msg_sequencer.sv
// Scoreboard bench for uart_msg_sequencer: scenarios push the bytes they
// expect to see accepted, a negedge monitor pops and compares on each transfer.
module tb_uart_msg_sequencer;

    localparam int MSG_LEN    = 16;
    localparam int GAP_CYCLES = 6;
    localparam int BUDGET     = 1000;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       repeat_en;
    logic       abort;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       busy;
    logic       msg_done;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         ready_mode = 0;
    logic       rand_bit = 1'b0;
    logic       manual_ready = 1'b0;
    logic       prev_pending = 1'b0;
    logic [7:0] prev_data = 8'h00;

    uart_msg_sequencer #(
        .MSG_LEN    (MSG_LEN),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .repeat_en (repeat_en),
        .abort     (abort),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .msg_done  (msg_done)
    );

    // 0: ready low, 1: ready high, 2: random ready, 3: manual single accepts
    assign tx_ready = (ready_mode == 1) || (ready_mode == 2 && rand_bit) ||
                      (ready_mode == 3 && manual_ready);

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter used for latency measurements
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Random ready source, updated just after each rising edge
    initial forever begin
        @(posedge clk);
        #1;
        rand_bit = 1'($urandom_range(0, 1));
    end

    // Expected message: the text, '.' padding, then CR LF in the last two slots
    function automatic logic [7:0] exp_byte(input int i);
        string text;
        text = "Hello UART msg";
        if (i == MSG_LEN - 1) return 8'h0A;
        if (i == MSG_LEN - 2) return 8'h0D;
        if (i < text.len()) return text[i];
        return 8'h2E;
    endfunction

    task automatic push_msg(input int first, input int count);
        for (int i = first; i < first + count; i++) begin
            sb_q.push_back({exp_byte(i), logic'(i == MSG_LEN - 1)});
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // One-cycle start pulse, sampled by the DUT on the following edge
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic set_ready_mode(input int m);
        ready_mode   = m;
        manual_ready = 1'b0;
    endtask

    // Sel 0: tx_valid high, 1: msg_done pulse, 2: busy low; sampled at negedge
    task automatic wait_cond(input int sel, input string name, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < BUDGET; n++) begin
            @(negedge clk);
            if ((sel == 0 && tx_valid === 1'b1) || (sel == 1 && msg_done === 1'b1) ||
                (sel == 2 && busy === 1'b0)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("[TB] FAIL timeout_%s: not seen in %0d cycles, required within budget", name, BUDGET);
            sb_q.delete();
        end
    endtask

    // Accept exactly one offered byte with a one-cycle ready pulse
    task automatic accept_one(input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < BUDGET; n++) begin
            @(posedge clk);
            #1;
            if (tx_valid === 1'b1) begin
                manual_ready = 1'b1;
                @(posedge clk);
                #1;
                manual_ready = 1'b0;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("[TB] FAIL timeout_%s: no byte offered in %0d cycles", name, BUDGET);
        end
    endtask

    // Monitor: compare every accepted byte against the scoreboard and
    // check that an offered byte stays put until it is taken
    initial forever begin
        @(negedge clk);
        if (reset !== 1'b0) begin
            prev_pending = 1'b0;
        end else begin
            if (prev_pending) begin
                total++;
                if (!(tx_valid === 1'b1 && tx_data === prev_data)) begin
                    bad++;
                    $display("[TB] FAIL hold: valid=%0b data=%0h, expected valid=1 data=%0h",
                             tx_valid, tx_data, prev_data);
                end
            end
            if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_byte: got %0h, expected no transfer", tx_data);
                end else begin
                    mon_e = sb_q.pop_front();
                    total++;
                    if (tx_data !== mon_e.data) begin
                        bad++;
                        $display("[TB] FAIL byte: got %0h, expected %0h", tx_data, mon_e.data);
                    end
                    total++;
                    if (msg_done !== mon_e.last) begin
                        bad++;
                        $display("[TB] FAIL msg_done: got %0b, expected %0b", msg_done, mon_e.last);
                    end
                end
            end else if (msg_done !== 1'b0) begin
                total++;
                bad++;
                $display("[TB] FAIL spurious_msg_done: got %0b without transfer, expected 0", msg_done);
            end
            prev_pending = (tx_valid === 1'b1) && (tx_ready !== 1'b1);
            prev_data    = tx_data;
        end
    end

    // Safety net in case something outside the bounded waits stalls
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence
    initial begin
        bit ok;
        int n;
        int t_done;

        reset     = 1'b1;
        start     = 1'b0;
        repeat_en = 1'b0;
        abort     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_tx_valid", 32'(tx_valid), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_tx_data", 32'(tx_data), 0);
        checkOutput("reset_msg_done", 32'(msg_done), 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("idle_busy", 32'(busy), 0);

        // One-shot messages with random back-pressure, then gap length
        for (int r = 0; r < 3; r++) begin
            set_ready_mode(2);
            push_msg(0, MSG_LEN);
            applyStimulus();
            wait_cond(1, "oneshot_done", ok);
            if (ok) begin
                n = 0;
                for (int k = 0; k < GAP_CYCLES + 5; k++) begin
                    @(negedge clk);
                    if (busy === 1'b1) n++;
                    else break;
                end
                checkOutput("oneshot_gap_len", 32'(n), 32'(GAP_CYCLES));
            end
            checkOutput("oneshot_drained", 32'(sb_q.size()), 0);
        end

        // Twenty stalled cycles on the first byte
        set_ready_mode(0);
        push_msg(0, MSG_LEN);
        applyStimulus();
        wait_cond(0, "stall_offer", ok);
        repeat (20) @(negedge clk);
        checkOutput("stall_valid", 32'(tx_valid), 1);
        checkOutput("stall_data", 32'(tx_data), 32'(exp_byte(0)));
        @(posedge clk);
        #1;
        set_ready_mode(2);
        wait_cond(1, "stall_done", ok);
        wait_cond(2, "stall_idle", ok);
        checkOutput("stall_drained", 32'(sb_q.size()), 0);

        // Repeat mode: restart latency, then stop by clearing repeat_en in the gap
        set_ready_mode(1);
        repeat_en = 1'b1;
        push_msg(0, MSG_LEN);
        push_msg(0, MSG_LEN);
        applyStimulus();
        wait_cond(1, "rep_done1", ok);
        t_done = cyc;
        wait_cond(0, "rep_restart", ok);
        checkOutput("rep_restart_latency", 32'(cyc - t_done), 32'(GAP_CYCLES + 2));
        wait_cond(1, "rep_done2", ok);
        @(posedge clk);
        #1;
        repeat_en = 1'b0;
        wait_cond(2, "rep_stop", ok);
        repeat (MSG_LEN + GAP_CYCLES + 5) @(negedge clk);
        checkOutput("rep_stopped_busy", 32'(busy), 0);
        checkOutput("rep_drained", 32'(sb_q.size()), 0);

        // Abort raised while byte 2 is stalled
        set_ready_mode(3);
        push_msg(0, 3);
        applyStimulus();
        accept_one("abort_b0");
        accept_one("abort_b1");
        wait_cond(0, "abort_b2_offer", ok);
        @(posedge clk);
        #1;
        abort = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("abort_hold_valid", 32'(tx_valid), 1);
        checkOutput("abort_hold_data", 32'(tx_data), 32'(exp_byte(2)));
        accept_one("abort_b2");
        checkOutput("abort_idle", 32'(busy), 0);
        abort = 1'b0;
        repeat (MSG_LEN * 3) @(negedge clk);
        checkOutput("abort_no_more", 32'(busy), 0);
        checkOutput("abort_drained", 32'(sb_q.size()), 0);

        // Random start pulses while a message is in flight are ignored
        set_ready_mode(2);
        push_msg(0, MSG_LEN);
        applyStimulus();
        for (int k = 0; k < BUDGET; k++) begin
            @(posedge clk);
            #1;
            if (sb_q.size() <= 2) break;
            start = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
        wait_cond(1, "busy_start_done", ok);
        wait_cond(2, "busy_start_idle", ok);
        repeat (MSG_LEN * 3) @(negedge clk);
        checkOutput("busy_start_idle", 32'(busy), 0);
        checkOutput("busy_start_drained", 32'(sb_q.size()), 0);

        // Abort during the gap of a repeating message
        set_ready_mode(1);
        repeat_en = 1'b1;
        push_msg(0, MSG_LEN);
        applyStimulus();
        wait_cond(1, "gap_abort_done", ok);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("gap_abort_idle", 32'(busy), 0);
        abort     = 1'b0;
        repeat_en = 1'b0;
        repeat (MSG_LEN * 3) @(negedge clk);
        checkOutput("gap_abort_drained", 32'(sb_q.size()), 0);

        // Reset while byte 2 is offered, then a clean message from byte 0
        set_ready_mode(3);
        push_msg(0, 2);
        applyStimulus();
        accept_one("rst_b0");
        accept_one("rst_b1");
        wait_cond(0, "rst_offer", ok);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("rst_tx_valid", 32'(tx_valid), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_ready_mode(1);
        push_msg(0, MSG_LEN);
        applyStimulus();
        wait_cond(1, "rst_resend_done", ok);
        wait_cond(2, "rst_resend_idle", ok);

        checkOutput("final_drained", 32'(sb_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
